// File: rtl/prbs15_checker.sv
`default_nettype none
// ============================================================================
// Module   : prbs15_checker
// Purpose  : Checks a repeated 4-byte preamble, then locks a local PRBS-15
//            (x^15+x^14+1) LFSR to the byte stream and counts mismatched bytes.
// Revision : 1.0  initial release
// ============================================================================
module prbs15_checker #(
  parameter int ERR_W       = 16,
  parameter int LOSS_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [7:0]       byte_in,
  input  logic [31:0]      bytes_in,
  input  logic [7:0]       n,
  output logic             pattern_done,
  output logic             pattern_err,
  output logic             prbs_lock,
  output logic             err_strobe,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PATTERN = 2'd1;
  localparam logic [1:0] S_SEED    = 2'd2;
  localparam logic [1:0] S_TRACK   = 2'd3;
  localparam logic [3:0] C_LOSS    = 4'(LOSS_THRESH);

  logic [1:0]       state_q, state_d;
  logic [7:0]       n_q, n_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       rep_q, rep_d;
  logic             seed_cnt_q, seed_cnt_d;
  logic [7:0]       seed_a_q, seed_a_d;
  logic [14:0]      hist_q, hist_d;
  logic [3:0]       miss_q, miss_d;
  logic             pattern_done_q, pattern_done_d;
  logic             pattern_err_q, pattern_err_d;
  logic             prbs_lock_q, prbs_lock_d;
  logic             err_strobe_q, err_strobe_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  logic [7:0]       pred_byte;
  logic [14:0]      hist_adv;
  logic [3:0]       miss_inc;

  // hist[0] is the oldest bit b[k-15], hist[14] the newest b[k-1].
  always_comb begin
    pred_byte = '0;
    hist_adv  = hist_q;
    for (int i = 0; i < 8; i++) begin
      pred_byte[i] = hist_adv[0] ^ hist_adv[1];
      hist_adv     = {pred_byte[i], hist_adv[14:1]};
    end
  end

  assign miss_inc = miss_q + 4'd1;

  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    idx_d          = idx_q;
    rep_d          = rep_q;
    seed_cnt_d     = seed_cnt_q;
    seed_a_d       = seed_a_q;
    hist_d         = hist_q;
    miss_d         = miss_q;
    pattern_done_d = pattern_done_q;
    pattern_err_d  = pattern_err_q;
    prbs_lock_d    = prbs_lock_q;
    err_strobe_d   = 1'b0;
    err_count_d    = err_count_q;
    if (enable) begin
      case (state_q)
        S_IDLE: begin
          n_d = n;
          if (n == 8'd0) begin
            state_d        = S_SEED;
            pattern_done_d = 1'b1;
            seed_a_d       = byte_in;
            seed_cnt_d     = 1'b1;
          end else begin
            state_d = S_PATTERN;
            if (byte_in != bytes_in[7:0]) pattern_err_d = 1'b1;
            idx_d = 2'd1;
            rep_d = 8'd0;
          end
        end
        S_PATTERN: begin
          if (byte_in != bytes_in[{idx_q, 3'b000} +: 8]) pattern_err_d = 1'b1;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            rep_d = rep_q + 8'd1;
            if (rep_q == n_q - 8'd1) begin
              pattern_done_d = 1'b1;
              state_d        = S_SEED;
              seed_cnt_d     = 1'b0;
            end
          end
        end
        S_SEED: begin
          if (!seed_cnt_q) begin
            seed_a_d   = byte_in;
            seed_cnt_d = 1'b1;
          end else begin
            // Window is A[1..7] followed by B[0..7], oldest first.
            hist_d      = {byte_in, seed_a_q[7:1]};
            seed_cnt_d  = 1'b0;
            miss_d      = 4'd0;
            prbs_lock_d = 1'b1;
            state_d     = S_TRACK;
          end
        end
        S_TRACK: begin
          hist_d = hist_adv;
          if (byte_in != pred_byte) begin
            err_strobe_d = 1'b1;
            if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
            if (miss_inc == C_LOSS) begin
              miss_d      = 4'd0;
              prbs_lock_d = 1'b0;
              seed_cnt_d  = 1'b0;
              state_d     = S_SEED;
            end else begin
              miss_d = miss_inc;
            end
          end else begin
            miss_d = 4'd0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      n_q            <= '0;
      idx_q          <= '0;
      rep_q          <= '0;
      seed_cnt_q     <= 1'b0;
      seed_a_q       <= '0;
      hist_q         <= '0;
      miss_q         <= '0;
      pattern_done_q <= 1'b0;
      pattern_err_q  <= 1'b0;
      prbs_lock_q    <= 1'b0;
      err_strobe_q   <= 1'b0;
      err_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      idx_q          <= idx_d;
      rep_q          <= rep_d;
      seed_cnt_q     <= seed_cnt_d;
      seed_a_q       <= seed_a_d;
      hist_q         <= hist_d;
      miss_q         <= miss_d;
      pattern_done_q <= pattern_done_d;
      pattern_err_q  <= pattern_err_d;
      prbs_lock_q    <= prbs_lock_d;
      err_strobe_q   <= err_strobe_d;
      err_count_q    <= err_count_d;
    end
  end

  assign pattern_done = pattern_done_q;
  assign pattern_err  = pattern_err_q;
  assign prbs_lock    = prbs_lock_q;
  assign err_strobe   = err_strobe_q;
  assign err_count    = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_prbs15_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_prbs15_checker
// Purpose  : Scoreboard bench for prbs15_checker (preamble, lock, errors).
// Revision : 1.0  initial release
// ============================================================================
module tb_prbs15_checker;

  logic        clk = 1'b0;
  logic        rst, enable;
  logic [7:0]  byte_in, n;
  logic [31:0] bytes_in;
  logic        pattern_done, pattern_err, prbs_lock, err_strobe;
  logic [2:0]  err_count;

  prbs15_checker #(.ERR_W(3), .LOSS_THRESH(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .byte_in(byte_in),
    .bytes_in(bytes_in), .n(n),
    .pattern_done(pattern_done), .pattern_err(pattern_err),
    .prbs_lock(prbs_lock), .err_strobe(err_strobe), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Expected vector: {done, perr, lock, strobe, cnt[2:0]}
  logic [6:0] exp_q[$];
  string      tag_q[$];
  int         n_cmp  = 0;
  int         n_fail = 0;

  // Reference serial PRBS-15: sb[0] = b[k-15], sb[1] = b[k-14].
  bit sb[$];

  function automatic logic [7:0] prbs_next();
    logic [7:0] r;
    bit nb;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      nb = sb[0] ^ sb[1];
      sb.push_back(nb);
      void'(sb.pop_front());
      r[j] = nb;
    end
    return r;
  endfunction

  task automatic step(input logic r, input logic en, input logic [7:0] b,
                      input logic e_done, input logic e_perr, input logic e_lock,
                      input logic e_strobe, input logic [2:0] e_cnt, input string tag);
    rst     = r;
    enable  = en;
    byte_in = b;
    @(posedge clk);
    exp_q.push_back({e_done, e_perr, e_lock, e_strobe, e_cnt});
    tag_q.push_back(tag);
    #1;
  endtask

  always @(negedge clk) begin
    logic [6:0] e, a;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {pattern_done, pattern_err, prbs_lock, err_strobe, err_count};
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s @%0t: got done=%b perr=%b lock=%b strobe=%b cnt=%0d, want done=%b perr=%b lock=%b strobe=%b cnt=%0d",
                 t, $time, a[6], a[5], a[4], a[3], a[2:0], e[6], e[5], e[4], e[3], e[2:0]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] seed;
    logic [31:0] word;
    logic [7:0]  b;
    int c;
    seed = 15'h1234;
    for (int i = 0; i < 15; i++) sb.push_back(seed[i]);
    rst = 1'b1; enable = 1'b0; byte_in = 8'h00;
    bytes_in = 32'hA1B2C3D4; n = 8'd3;
    word = bytes_in;

    step(1, 0, 8'h00, 0, 0, 0, 0, 3'd0, "reset0");
    step(1, 1, 8'hFF, 0, 0, 0, 0, 3'd0, "reset1");

    // Clean preamble, then two seed bytes lock the tracker.
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 4; i++)
        step(0, 1, word[8*i +: 8], (r == 2 && i == 3), 0, 0, 0, 3'd0, "pre_pass");
    step(0, 1, prbs_next(), 1, 0, 0, 0, 3'd0, "pre_seed_a");
    step(0, 1, prbs_next(), 1, 0, 1, 0, 3'd0, "pre_seed_b");
    step(1, 0, 8'h00, 0, 0, 0, 0, 3'd0, "rst_a");

    // Preamble with the 6th byte corrupted.
    c = 0;
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 4; i++) begin
        b = (c == 5) ? 8'h00 : word[8*i +: 8];
        step(0, 1, b, (r == 2 && i == 3), (c >= 5), 0, 0, 3'd0, "pre_err");
        c++;
      end
    step(1, 0, 8'h00, 0, 0, 0, 0, 3'd0, "rst_b");

    // n = 0: straight to SEED, then 200 clean checked bytes.
    n = 8'd0;
    step(0, 1, prbs_next(), 1, 0, 0, 0, 3'd0, "n0_seed_a");
    n = 8'd7;
    step(0, 1, prbs_next(), 1, 0, 1, 0, 3'd0, "n0_lock");
    for (int i = 0; i < 200; i++)
      step(0, 1, prbs_next(), 1, 0, 1, 0, 3'd0, "clean");

    // Four consecutive bad bytes drop lock; two good bytes relock.
    for (int k = 1; k <= 4; k++)
      step(0, 1, prbs_next() ^ 8'hFF, 1, 0, (k < 4), 1, 3'(k), "loss");
    step(0, 1, prbs_next(), 1, 0, 0, 0, 3'd4, "relock_a");
    step(0, 1, prbs_next(), 1, 0, 1, 0, 3'd4, "relock_b");
    for (int i = 0; i < 50; i++)
      step(0, 1, prbs_next(), 1, 0, 1, 0, 3'd4, "post_relock");

    // Single flipped bit costs exactly one error.
    step(0, 1, prbs_next() ^ 8'h20, 1, 0, 1, 1, 3'd5, "flip");
    for (int i = 0; i < 10; i++)
      step(0, 1, prbs_next(), 1, 0, 1, 0, 3'd5, "post_flip");

    // Alternate enable gaps: idle cycles carry garbage and change nothing.
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) step(0, 1, prbs_next(), 1, 0, 1, 0, 3'd5, "gap_on");
      else            step(0, 0, 8'h5A,       1, 0, 1, 0, 3'd5, "gap_off");
    end

    // Saturation at 3'b111 while losing lock again.
    step(0, 1, prbs_next() ^ 8'h01, 1, 0, 1, 1, 3'd6, "sat1");
    step(0, 1, prbs_next() ^ 8'h80, 1, 0, 1, 1, 3'd7, "sat2");
    step(0, 0, 8'h00,               1, 0, 1, 0, 3'd7, "sat_gap");
    step(0, 1, prbs_next() ^ 8'h10, 1, 0, 1, 1, 3'd7, "sat3");
    step(0, 1, prbs_next() ^ 8'h42, 1, 0, 0, 1, 3'd7, "sat4");
    step(0, 1, prbs_next(), 1, 0, 0, 0, 3'd7, "sat_relock_a");
    step(0, 1, prbs_next(), 1, 0, 1, 0, 3'd7, "sat_relock_b");
    for (int i = 0; i < 5; i++)
      step(0, 1, prbs_next(), 1, 0, 1, 0, 3'd7, "sat_track");

    // Reset mid-TRACK overrides enable; IDLE then honours n = 0.
    step(1, 1, prbs_next(), 0, 0, 0, 0, 3'd0, "rst_track");
    step(0, 0, 8'h00,       0, 0, 0, 0, 3'd0, "idle_hold");
    n = 8'd0;
    step(0, 1, prbs_next(), 1, 0, 0, 0, 3'd0, "idle_reentry");

    enable = 1'b0;
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prbs15_checker.md
Name: prbs15_checker

Overview:
- Receive-side companion to the PRBS-15 pattern generator; sits directly downstream and consumes its 8-bit byte stream.
- Verifies the leading preamble: the 4-byte word repeated n times.
- Then self-synchronises a local PRBS-15 LFSR to the received stream and counts mismatching bytes.
- Outputs feed loopback/BIST status logic.

Parameters:
- ERR_W, 16, width of the PRBS byte-error counter (saturating).
- LOSS_THRESH, 4, consecutive mismatching PRBS bytes that drop lock (range 1..15).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  byte_in valid on this edge; when low, all state holds.
- byte_in  in  8  received byte.
- bytes_in  in  32  expected preamble word; byte order [7:0], [15:8], [23:16], [31:24].
- n  in  8  preamble repetitions; sampled when leaving IDLE.
- pattern_done  out  1  sticky; preamble phase complete.
- pattern_err  out  1  sticky; at least one preamble byte mismatched.
- prbs_lock  out  1  high while in TRACK.
- err_strobe  out  1  one-cycle pulse per mismatching PRBS byte.
- err_count  out  ERR_W  mismatching PRBS bytes counted, saturating at all-ones.

Behaviour:
- Reset: state IDLE; all outputs 0; all internal counters and LFSR cleared.
- All outputs are registered. The result for a byte sampled at edge k is visible after edge k.
- enable=0: no state, counter or output change, except that err_strobe drops to 0.
- PRBS bit ordering: byte bit 0 is the earliest serial bit. Serial recurrence: b[k] = b[k-15] XOR b[k-14] (x^15+x^14+1). Eight bits are produced per byte.
- IDLE: on the first enable=1 edge, latch n into n_q, then:
  - n_q=0: go to SEED; pattern_done=1 this same edge; that byte is treated as SEED byte A.
  - otherwise: go to PATTERN and process that byte as preamble byte 0.
- PATTERN:
  - 2-bit byte index and 8-bit repetition counter.
  - Compare byte_in against the indexed byte of bytes_in; on mismatch set pattern_err.
  - The index wraps 3->0 and increments the repetition counter.
  - After byte index 3 of repetition n_q-1 (4*n_q bytes total): set pattern_done, go to SEED.
- SEED:
  - Capture 2 bytes (A, B) with no checking.
  - The 15 most recent serial bits (A[1..7], B[0..7]) load the local LFSR history.
  - Go to TRACK on the edge that captures B.
- TRACK:
  - Each enabled edge: generate the predicted byte from the local history and compare with byte_in.
  - Advance the history with the predicted bits (free-running), not the received bits, so one flipped bit costs exactly one error.
  - Mismatch: err_strobe=1, err_count+1 (saturate), increment the consecutive-miss counter.
  - Match: clear the consecutive-miss counter.
  - Consecutive-miss counter reaches LOSS_THRESH: prbs_lock=0, go to SEED, clear the miss counter. err_count retains its value, and the bytes that caused loss are counted.
- Lock is never re-entered through PATTERN; only rst restarts the preamble phase.
- Changing n or bytes_in mid-PATTERN: n is ignored (latched); bytes_in is used live.
- rst during any state: next edge returns to IDLE with all outputs 0; overrides enable.
- prbs_lock becomes 1 on the edge the FSM enters TRACK, and 0 on the edge it leaves TRACK.
- Simultaneous events (mismatch with err_count saturated): strobe still pulses; count holds at all-ones.

Test Plan:
- Preamble pass: rst; bytes_in=32'hA1B2C3D4, n=3; feed D4,C3,B2,A1 x3 with enable=1 -> pattern_done=1 after the 12th byte; pattern_err=0; FSM enters SEED.
- Preamble error: same setup, 6th byte = 8'h00 instead of C3 -> pattern_err=1 from the 7th edge onward, sticky; pattern_done still set after 12 bytes.
- n=0 then clean PRBS: first byte goes to SEED.
  - Feed 202 bytes of a reference PRBS-15 model from any phase.
  - prbs_lock=1 after the 2nd byte; err_count=0 after all 200 checked bytes; err_strobe never high.
- Single bit flip: locked stream, flip bit 5 of one byte -> err_strobe high for exactly one cycle; err_count=1; prbs_lock stays 1; following bytes match.
- Lock loss/relock, LOSS_THRESH=4:
  - Corrupt 4 consecutive bytes -> err_count=4 and prbs_lock=0 after the 4th.
  - 2 further good bytes -> prbs_lock=1.
  - Then 50 good bytes -> err_count stays 4.
- enable gaps and reset: a locked stream with enable low on alternate cycles -> no errors, err_count unchanged. Assert rst mid-TRACK -> all outputs 0 the next cycle; FSM in IDLE.
